// File: rtl/mux_arb_nto1.sv
// N-to-1 registered selector with valid/ready on every channel: addressed or round-robin grant.
// Optional even parity on the held word when MUX_ARB_PARITY_EN is defined.
module mux_arb_nto1 #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         mode,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic [NUM_INPUTS-1:0]        in_valid,
    input  logic [NUM_INPUTS*WIDTH-1:0]  in_data,
    output logic [NUM_INPUTS-1:0]        in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [ADDR_WIDTH-1:0]        out_chan,
    input  logic                         out_ready,
    output logic                         out_parity,
    output logic                         o_dbg_state
);

    // Handshake: a word moves on a rising Clk edge when valid and ready are both high.
    // in_ready may depend on in_valid; in_valid must never depend on in_ready.

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] L_N = (ADDR_WIDTH + 1)'(NUM_INPUTS);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [WIDTH-1:0]        r_data;
    logic [ADDR_WIDTH-1:0]   r_chan;

    logic [NUM_INPUTS-1:0]   w_addr_onehot;
    logic                    w_addr_hit;

    logic [2*NUM_INPUTS-1:0] w_dbl;
    logic [NUM_INPUTS-1:0]   w_rot;
    logic                    w_rr_valid;
    logic [ADDR_WIDTH-1:0]   w_rr_off;
    logic [ADDR_WIDTH:0]     w_rr_sum;
    logic [ADDR_WIDTH-1:0]   w_rr_idx;

    logic                    w_grant_valid;
    logic [ADDR_WIDTH-1:0]   w_grant_idx;
    logic [NUM_INPUTS-1:0]   w_grant_onehot;
    logic [WIDTH-1:0]        w_sel_data;

    logic                    w_can_load;
    logic                    w_load;
    logic [ADDR_WIDTH:0]     w_ptr_inc;
    logic [ADDR_WIDTH-1:0]   w_ptr_next;

    // Addressed grant: an address beyond the last channel simply matches no bit.
    always_comb begin
        w_addr_onehot = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_addr_onehot[k] = (address == ADDR_WIDTH'(k));
        end
        w_addr_hit = |(w_addr_onehot & in_valid);
    end

    // Round-robin: rotate so bit 0 is the pointer channel, then take the lowest set bit.
    assign w_dbl = {in_valid, in_valid};
    assign w_rot = NUM_INPUTS'(w_dbl >> r_ptr);

    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_off   = '0;
        for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_rr_valid = 1'b1;
                w_rr_off   = ADDR_WIDTH'(j);
            end
        end
    end

    always_comb begin
        w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rr_off};
        if (w_rr_sum >= L_N) begin
            w_rr_sum = w_rr_sum - L_N;
        end
        w_rr_idx = w_rr_sum[ADDR_WIDTH-1:0];
    end

    assign w_grant_valid = mode ? w_rr_valid : w_addr_hit;
    assign w_grant_idx   = mode ? w_rr_idx   : address;

    always_comb begin
        w_grant_onehot = '0;
        w_sel_data     = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_grant_onehot[k] = w_grant_valid & (w_grant_idx == ADDR_WIDTH'(k));
            if (w_grant_onehot[k]) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_can_load = (r_state == ST_EMPTY) | ((r_state == ST_FULL) & out_ready);
    assign w_load     = w_can_load & w_grant_valid & ~Reset;
    assign in_ready   = w_load ? w_grant_onehot : '0;

    always_comb begin
        w_ptr_inc = {1'b0, w_grant_idx} + 1'b1;
        if (w_ptr_inc >= L_N) begin
            w_ptr_inc = '0;
        end
        w_ptr_next = w_ptr_inc[ADDR_WIDTH-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !w_load) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The pointer only advances when a round-robin grant is actually accepted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
        end else if (w_load && mode) begin
            r_ptr <= w_ptr_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data <= '0;
            r_chan <= '0;
        end else if (w_load) begin
            r_data <= w_sel_data;
            r_chan <= w_grant_idx;
        end
    end

`ifdef MUX_ARB_PARITY_EN
    logic r_parity;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_sel_data;
        end
    end

    assign out_parity = r_parity;
`else
    assign out_parity = 1'b0;
`endif

    assign out_valid   = (r_state == ST_FULL);
    assign out_data    = r_data;
    assign out_chan    = r_chan;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: directed cases plus randomized traffic against a grant model,
// with an expected-word queue checked by an independent output monitor.
module tb_mux_arb_nto1;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int A  = 5;
    localparam int N2 = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           mode;
    logic [A-1:0]   address;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [A-1:0]   out_chan;
    logic           out_ready;
    logic           out_parity;
    logic           dbg_state;

    logic            b_mode;
    logic [A-1:0]    b_address;
    logic [N2-1:0]   b_in_valid;
    logic [N2*W-1:0] b_in_data;
    logic [N2-1:0]   b_in_ready;
    logic            b_out_valid;
    logic [W-1:0]    b_out_data;
    logic [A-1:0]    b_out_chan;
    logic            b_out_ready;
    logic            b_out_parity;
    logic            b_dbg_state;

    mux_arb_nto1 #(.WIDTH(W), .NUM_INPUTS(N), .ADDR_WIDTH(A)) u_dut (
        .Clk(clk), .Reset(rst), .mode(mode), .address(address),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .out_parity(out_parity), .o_dbg_state(dbg_state)
    );

    mux_arb_nto1 #(.WIDTH(W), .NUM_INPUTS(N2), .ADDR_WIDTH(A)) u_dut24 (
        .Clk(clk), .Reset(rst), .mode(b_mode), .address(b_address),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_chan(b_out_chan),
        .out_ready(b_out_ready), .out_parity(b_out_parity), .o_dbg_state(b_dbg_state)
    );

    logic [W+A-1:0] exp_q[$];
    int             m_ptr;
    int             n_checks;
    int             n_fail;
    bit             mon_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [W-1:0] d);
`ifdef MUX_ARB_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Reference grant: returns the granted channel, or -1 when nobody is granted.
    function automatic int model_grant(input bit m, input int addr, input logic [N-1:0] v, input int p);
        if (!m) begin
            if (addr < N) begin
                if (v[addr]) return addr;
            end
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit m, input int addr, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input bit ordy);
        int           g;
        bit           load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        mode      = m;
        address   = addr[A-1:0];
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        g       = model_grant(m, addr, v, m_ptr);
        load    = ((exp_q.size() == 0) || ordy) && (g >= 0);
        exp_rdy = '0;
        if (load) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (load) begin
            exp_q.push_back({A'(g), d[g*W +: W]});
            if (m) m_ptr = (g + 1) % N;
        end
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = $urandom();
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '1;
        mode      = 1'b0;
        address   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_out_parity", 64'(out_parity), 64'd0);
        exp_q.delete();
        m_ptr = 0;
        @(negedge clk);
        #1;
        chk("rst_in_ready_hold", 64'(in_ready), 64'd0);
        in_valid = '0;
        rst      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, '0, 1'b1);
    endtask

    // Monitor: compares the held word against the queue head; pops when the consumer takes it.
    initial begin
        logic [W+A-1:0] front;
        forever begin
            @(negedge clk);
            #2;
            if (mon_on && !rst) begin
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0 && out_valid) begin
                    front = exp_q[0];
                    chk("out_data", 64'(out_data), 64'(front[W-1:0]));
                    chk("out_chan", 64'(out_chan), 64'(front[W+A-1:W]));
                    chk("out_parity", 64'(out_parity), 64'(exp_par(front[W-1:0])));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   v;
        n_checks = 0;
        n_fail   = 0;
        mon_on   = 1'b0;
        m_ptr    = 0;
        rst = 1'b1; mode = 1'b0; address = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        b_mode = 1'b0; b_address = '0; b_in_valid = '0; b_out_ready = 1'b0;
        for (int k = 0; k < N2; k++) b_in_data[k*W +: W] = $urandom();
        repeat (2) @(negedge clk);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_out_data", 64'(out_data), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Addressed single word.
        d = rand_data();
        d[5*W +: W] = 32'hDEADBEEF;
        cycle(1'b0, 5, 32'h20, d, 1'b1);
        drain();

        // Reset, then the first round-robin grant must be channel 0.
        do_reset();
        cycle(1'b1, 0, '1, rand_data(), 1'b1);
        drain();

        // Round-robin fairness across 2, 7, 31 with pointer wrap.
        v = '0; v[2] = 1'b1; v[7] = 1'b1; v[31] = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 0, v, rand_data(), 1'b1);
        drain();

        // Stall with a held word, then consume and reload on the same edge.
        d = rand_data();
        d[1*W +: W] = 32'h1234;
        cycle(1'b0, 1, 32'h2, d, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4, 32'h10, rand_data(), 1'b0);
        cycle(1'b0, 4, 32'h10, rand_data(), 1'b1);
        drain();

        // Parity patterns.
        d = rand_data();
        d[3*W +: W] = 32'h7;
        cycle(1'b0, 3, 32'h8, d, 1'b1);
        d[3*W +: W] = 32'h3;
        cycle(1'b0, 3, 32'h8, d, 1'b1);
        drain();

        // Randomized traffic with a reset in the middle of the stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            v = $urandom() & $urandom();
            if ($urandom_range(0, 7) == 0) v = '0;
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), v, rand_data(),
                  $urandom_range(0, 3) != 0);
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // 24-channel instance: out-of-range addresses never grant.
        for (int a = N2; a < (1 << A); a++) begin
            @(negedge clk);
            b_mode = 1'b0; b_address = A'(a); b_in_valid = '1; b_out_ready = 1'b1;
            #1;
            chk("b_in_ready_oob", 64'(b_in_ready), 64'd0);
            chk("b_out_valid_oob", 64'(b_out_valid), 64'd0);
        end
        @(negedge clk);
        b_address = A'(N2 - 1);
        #1;
        chk("b_in_ready_last", 64'(b_in_ready), 64'h800000);
        @(posedge clk);
        #1;
        chk("b_out_valid_last", 64'(b_out_valid), 64'd1);
        chk("b_out_chan_last", 64'(b_out_chan), 64'(N2 - 1));
        chk("b_out_data_last", 64'(b_out_data), 64'(b_in_data[(N2-1)*W +: W]));
        b_in_valid = '0;

        mon_on = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
